falling_objects_ctrl: RTL

Parametrised manager for up to NUM_OBJ independent falling sprites (trees/towers) in the VGA pipeline. Each slot has an alive flag and fixed-point X/Y. Slots are spawned on a frame timer at pseudo-random grid-aligned X positions, fall each frame, and despawn off-screen or when hit. For every scanned pixel the block produces a priority-resolved drawing request, sprite offsets and the index of the drawn object. A collision input from the collision matrix kills the drawn object and raises a hit pulse.

---
 rtl/falling_objects_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/falling_objects_ctrl.sv
// Falling-object slot manager: frame-timed spawning at grid-aligned X, per-frame fall,
// hit kill from the collision matrix, and a registered priority-resolved pixel request.

module falling_objects_slot #(
   parameter int OBJ_W      = 28,
   parameter int OBJ_H      = 58,
   parameter int SCREEN_H   = 480,
   parameter int FRAC_BITS  = 6,
   parameter int FALL_SPEED = 100,
   localparam int PW        = 11 + FRAC_BITS
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               kill,
   input  logic               move,
   input  logic               spawn,
   input  logic signed [11:0] spawnPosX,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   output logic               alive,
   output logic               hit,
   output logic [10:0]        offX,
   output logic [10:0]        offY
);
   localparam logic signed [PW-1:0] SPAWN_Y = PW'(-OBJ_H * (2 ** FRAC_BITS));
   localparam logic signed [10:0]   LIM_Y   = 11'(SCREEN_H);

   logic signed [11:0]   posX;
   logic signed [PW-1:0] posY;
   logic signed [10:0]   pixY;
   logic signed [12:0]   ox, oy, px, py;

   assign pixY = posY[PW-1:FRAC_BITS];
   assign ox   = 13'(posX);
   assign oy   = 13'(pixY);
   assign px   = {2'b00, pixelX};
   assign py   = {2'b00, pixelY};
   assign hit  = alive && (px >= ox) && (px < ox + 13'(OBJ_W))
                       && (py >= oy) && (py < oy + 13'(OBJ_H));
   assign offX = pixelX - posX[10:0];
   assign offY = pixelY - pixY;

   // Kill outranks motion; spawn only ever targets a free slot.
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         alive <= 1'b0;
         posX  <= '0;
         posY  <= '0;
      end else if (kill) begin
         alive <= 1'b0;
      end else if (move && alive) begin
         if (pixY > LIM_Y) alive <= 1'b0;
         else              posY  <= posY + PW'(FALL_SPEED);
      end else if (spawn) begin
         alive <= 1'b1;
         posX  <= spawnPosX;
         posY  <= SPAWN_Y;
      end
endmodule

module falling_objects_ctrl #(
   parameter int          NUM_OBJ    = 8,
   parameter int          OBJ_W      = 28,
   parameter int          OBJ_H      = 58,
   parameter int          SCREEN_W   = 640,
   parameter int          SCREEN_H   = 480,
   parameter int          FRAC_BITS  = 6,
   parameter int          FALL_SPEED = 100,
   parameter int          SPAWN_WAIT = 100,
   parameter int          GRID       = 64,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
   localparam int         CW = $clog2(NUM_OBJ + 1)
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   input  logic signed [10:0] spawnX,
   input  logic [CW-1:0]      activeLimit,
   input  logic               pause,
   input  logic               collisionIn,
   output logic               drawingRequest,
   output logic [10:0]        offsetX,
   output logic [10:0]        offsetY,
   output logic [IW-1:0]      objIndex,
   output logic [CW-1:0]      activeCount,
   output logic               hitPulse
);
   localparam int          TW        = (SPAWN_WAIT > 0) ? $clog2(SPAWN_WAIT + 1) : 1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   logic [NUM_OBJ-1:0]        alive, hitv, killv, spawnv;
   logic [NUM_OBJ-1:0][10:0]  offXv, offYv;
   logic [TW-1:0]             timer;
   logic [15:0]               lfsr;
   logic                      move, spawnOk, kill, freeFound, selHit;
   logic [IW-1:0]             freeIdx, selIdx;
   logic [CW-1:0]             popCnt;
   logic [10:0]               selOffX, selOffY;
   logic signed [11:0]        spawnSum, spawnWrap, spawnPos;

   // Guard on alive: the registered request still shows a just-killed slot for a cycle.
   assign kill    = collisionIn & drawingRequest & alive[objIndex];
   assign move    = startOfFrame & ~pause;
   assign spawnOk = move & (timer == '0) & freeFound & (activeCount < activeLimit);

   always_comb begin
      spawnSum  = 12'(spawnX) + $signed({3'b000, lfsr[8:0]});
      spawnWrap = spawnSum;
      if (spawnSum < 0)                    spawnWrap = spawnSum + 12'(SCREEN_W);
      else if (spawnSum >= 12'(SCREEN_W))  spawnWrap = spawnSum - 12'(SCREEN_W);
      spawnPos = spawnWrap;
      if (spawnWrap < 0)                          spawnPos = '0;
      else if (spawnWrap > 12'(SCREEN_W - GRID))  spawnPos = 12'(SCREEN_W - GRID);
      spawnPos = spawnPos & ~12'(GRID - 1);
   end

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
      assign killv[g]  = kill    && (objIndex == IW'(g));
      assign spawnv[g] = spawnOk && (freeIdx  == IW'(g));
      falling_objects_slot #(
         .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCREEN_H(SCREEN_H),
         .FRAC_BITS(FRAC_BITS), .FALL_SPEED(FALL_SPEED)
      ) u_slot (
         .clk(clk), .resetN(resetN), .kill(killv[g]), .move(move), .spawn(spawnv[g]),
         .spawnPosX(spawnPos), .pixelX(pixelX), .pixelY(pixelY),
         .alive(alive[g]), .hit(hitv[g]), .offX(offXv[g]), .offY(offYv[g])
      );
   end

   // Descending scan so the lowest index is the last (winning) assignment.
   always_comb begin
      selHit    = 1'b0;
      selIdx    = '0;
      selOffX   = '0;
      selOffY   = '0;
      freeFound = 1'b0;
      freeIdx   = '0;
      popCnt    = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (hitv[i]) begin
            selHit  = 1'b1;
            selIdx  = IW'(i);
            selOffX = offXv[i];
            selOffY = offYv[i];
         end
         if (!alive[i]) begin
            freeFound = 1'b1;
            freeIdx   = IW'(i);
         end
         popCnt = popCnt + CW'(alive[i]);
      end
   end

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         drawingRequest <= 1'b0;
         offsetX        <= '0;
         offsetY        <= '0;
         objIndex       <= '0;
         activeCount    <= '0;
         hitPulse       <= 1'b0;
         timer          <= TW'(SPAWN_WAIT);
         lfsr           <= LFSR_SEED;
      end else begin
         drawingRequest <= selHit;
         offsetX        <= selOffX;
         offsetY        <= selOffY;
         objIndex       <= selIdx;
         activeCount    <= popCnt;
         hitPulse       <= kill;
         lfsr           <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
         if (move) timer <= (timer == '0) ? TW'(SPAWN_WAIT) : timer - TW'(1);
      end
endmodule
